// File: rtl/median_window3x3_if.sv
// Pixel-stream and window bus between the raster source, the 3x3 window
// generator and the downstream median sorter.
interface median_window3x3_if #(
  parameter int WIDTH = 8
);
  logic               IN_VALID;
  logic               IN_SOF;
  logic [WIDTH-1:0]   IN_PIX;
  logic               OUT_VALID;
  logic [9*WIDTH-1:0] WIN;
  logic               SOF_ERR;

  modport master (
    output IN_VALID, IN_SOF, IN_PIX,
    input  OUT_VALID, WIN, SOF_ERR
  );

  modport slave (
    input  IN_VALID, IN_SOF, IN_PIX,
    output OUT_VALID, WIN, SOF_ERR
  );
endinterface

// File: rtl/median_window3x3.sv
// Line-buffered 3x3 neighbourhood generator feeding the median sorter.
// Optional mid-line SOF detection is built when MEDIAN_WIN_SOF_CHECK_EN is defined.
module median_window3x3 #(
  parameter int WIDTH    = 8,
  parameter int LINE_LEN = 640
) (
  input logic               CLK,
  input logic               nRST,
  median_window3x3_if.slave bus
);
  localparam int COL_W = $clog2(LINE_LEN);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] FIRST_INT_COL = COL_W'(2);

  typedef logic [WIDTH-1:0] pix_t;

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [1:0]       row_q, row_d, cur_row;
  logic             out_valid_q, out_valid_d;
  pix_t             win_q [9];
  pix_t             win_d [9];
  pix_t             lb1_mem [LINE_LEN];
  pix_t             lb2_mem [LINE_LEN];
  pix_t             lb1_rd, lb2_rd;

  // An accepted SOF pixel is (0,0) regardless of where the counters point.
  assign cur_col = bus.IN_SOF ? '0 : col_q;
  assign cur_row = bus.IN_SOF ? '0 : row_q;
  assign lb1_rd  = lb1_mem[cur_col];
  assign lb2_rd  = lb2_mem[cur_col];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = 1'b0;
    if (bus.IN_VALID) begin
      out_valid_d = (cur_row == 2'd2) && (cur_col >= FIRST_INT_COL);
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]     = win_q[3*i + 1];
        win_d[3*i + 1] = win_q[3*i + 2];
      end
      win_d[2] = lb2_rd;
      win_d[5] = lb1_rd;
      win_d[8] = bus.IN_PIX;
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == 2'd2) ? cur_row : cur_row + 2'd1;
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!nRST) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
    end
  end

  // NOTE: line buffers carry no reset so they can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (bus.IN_VALID) begin
      lb2_mem[cur_col] <= lb1_rd;
      lb1_mem[cur_col] <= bus.IN_PIX;
    end
  end

  assign bus.OUT_VALID = out_valid_q;
  for (genvar k = 0; k < 9; k++) begin : g_win
    assign bus.WIN[WIDTH*k +: WIDTH] = win_q[k];
  end

`ifdef MEDIAN_WIN_SOF_CHECK_EN
  logic sof_err_q, sof_err_d;

  assign sof_err_d = sof_err_q | (bus.IN_VALID & bus.IN_SOF & (col_q != '0));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) sof_err_q <= 1'b0;
    else       sof_err_q <= sof_err_d;
  end

  assign bus.SOF_ERR = sof_err_q;
`else
  assign bus.SOF_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_median_window3x3.sv
// Scoreboard bench for median_window3x3: the driver pushes expected windows
// from a frame-array model, a negedge monitor pops and compares them.
module tb_median_window3x3;
  localparam int WIDTH    = 8;
  localparam int LINE_LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  median_window3x3_if #(.WIDTH(WIDTH)) dut_if ();

  median_window3x3 #(.WIDTH(WIDTH), .LINE_LEN(LINE_LEN)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (dut_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  logic acc_last = 1'b0;
  logic [71:0] exp_q [$];
  logic [71:0] win_log [$];

  // Reference model: pixels stored by their frame position (r,c).
  logic [7:0] mem [0:15][0:LINE_LEN-1];
  int m_r = 0;
  int m_c = 0;

`ifdef MEDIAN_WIN_SOF_CHECK_EN
  localparam logic EXP_MIDLINE_ERR = 1'b1;
`else
  localparam logic EXP_MIDLINE_ERR = 1'b0;
`endif

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic sof, input logic [7:0] p);
    logic [71:0] w;
    w = '0;
    if (sof) begin
      m_r = 0;
      m_c = 0;
    end
    mem[m_r][m_c] = p;
    if (m_r >= 2 && m_c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[8*(3*i + j) +: 8] = mem[m_r - 2 + i][m_c - 2 + j];
      exp_q.push_back(w);
    end
    m_c++;
    if (m_c == LINE_LEN) begin
      m_c = 0;
      m_r++;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; idle cycles carry junk SOF.
  task automatic drive(input logic sof, input logic [7:0] p, input int gap);
    dut_if.IN_VALID = 1'b0;
    repeat (gap) begin
      dut_if.IN_SOF = 1'($urandom);
      dut_if.IN_PIX = 8'($urandom);
      @(posedge clk);
      #1;
    end
    dut_if.IN_VALID = 1'b1;
    dut_if.IN_SOF   = sof;
    dut_if.IN_PIX   = p;
    @(posedge clk);
    #1;
    dut_if.IN_VALID = 1'b0;
    dut_if.IN_SOF   = 1'b0;
    dut_if.IN_PIX   = 8'($urandom);
    model_accept(sof, p);
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle between pixels, 2 random 0..2 idles.
  task automatic send_frame(input int rows, input logic sof_first, input int gap_mode, input logic rnd);
    logic sof;
    logic [7:0] p;
    int r, c, gap;
    for (int n = 0; n < rows * LINE_LEN; n++) begin
      sof = sof_first && (n == 0);
      r   = sof ? 0 : m_r;
      c   = sof ? 0 : m_c;
      p   = rnd ? 8'($urandom) : 8'(16 * r + c);
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((n == 0) ? 0 : 1) : int'($urandom_range(0, 2));
      drive(sof, p, gap);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) acc_last <= rst_n && dut_if.IN_VALID;

  always @(negedge clk) begin
    if (rst_n && dut_if.OUT_VALID) begin
      check("valid_follows_accept", {71'd0, acc_last}, 72'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got WIN=%h, expected no window", dut_if.WIN);
      end else begin
        check("win", dut_if.WIN, exp_q.pop_front());
      end
      pulses++;
      win_log.push_back(dut_if.WIN);
    end
  end

  initial begin
    int base;
    dut_if.IN_VALID = 1'b0;
    dut_if.IN_SOF   = 1'b0;
    dut_if.IN_PIX   = '0;

    // 1: asynchronous reset, no clock edge yet
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {71'd0, dut_if.OUT_VALID}, 72'd0);
    check("rst_win", dut_if.WIN, 72'd0);
    check("rst_sof_err", {71'd0, dut_if.SOF_ERR}, 72'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 2: continuous 5-row frame
    base = pulses;
    send_frame(5, 1'b1, 0, 1'b0);
    settle();
    check("t2_pulses", 72'(pulses - base), 72'd6);
    if (pulses > base) begin
      check("t2_first_win", win_log[base], 72'h222120121110020100);
      check("t2_last_centre", {64'd0, win_log[win_log.size() - 1][39:32]}, 72'h32);
    end
    check("t2_sof_err", {71'd0, dut_if.SOF_ERR}, 72'd0);

    // 3: same frame with IN_VALID toggling
    base = pulses;
    send_frame(5, 1'b1, 1, 1'b0);
    settle();
    check("t3_pulses", 72'(pulses - base), 72'd6);
    check("t3_sof_err", {71'd0, dut_if.SOF_ERR}, 72'd0);

    // 4: mid-line SOF at (2,1)
    base = pulses;
    send_frame(2, 1'b1, 0, 1'b0);
    drive(1'b0, 8'h20, 0);
    settle();
    check("t4_pulses_before_sof", 72'(pulses - base), 72'd0);
    send_frame(3, 1'b1, 2, 1'b0);
    settle();
    check("t4_pulses", 72'(pulses - base), 72'd2);
    check("t4_sof_err", {71'd0, dut_if.SOF_ERR}, {71'd0, EXP_MIDLINE_ERR});

    // 5: reset pulse after (3,2), restart without SOF
    base = pulses;
    send_frame(3, 1'b1, 2, 1'b0);
    for (int c = 0; c < 3; c++) drive(1'b0, 8'(16 * 3 + c), 0);
    check("t5_valid_before_reset", {71'd0, dut_if.OUT_VALID}, 72'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    m_r = 0;
    m_c = 0;
    #1;
    check("t5_reset_valid", {71'd0, dut_if.OUT_VALID}, 72'd0);
    check("t5_reset_win", dut_if.WIN, 72'd0);
    check("t5_reset_sof_err", {71'd0, dut_if.SOF_ERR}, 72'd0);
    check("t5_pulses_before_reset", 72'(pulses - base), 72'd2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = pulses;
    send_frame(3, 1'b0, 2, 1'b0);
    settle();
    check("t5_pulses_after_reset", 72'(pulses - base), 72'd2);

    // 6: back-to-back frames, second SOF exactly at col 0
    base = pulses;
    send_frame(4, 1'b1, 0, 1'b0);
    settle();
    check("t6_frame1_pulses", 72'(pulses - base), 72'd4);
    base = pulses;
    send_frame(2, 1'b1, 0, 1'b0);
    settle();
    check("t6_rows01_pulses", 72'(pulses - base), 72'd0);
    check("t6_sof_err", {71'd0, dut_if.SOF_ERR}, 72'd0);
    send_frame(2, 1'b0, 0, 1'b0);
    settle();
    check("t6_frame2_pulses", 72'(pulses - base), 72'd4);

    // 7: random pixel values with random gaps
    base = pulses;
    send_frame(6, 1'b1, 2, 1'b1);
    settle();
    check("t7_pulses", 72'(pulses - base), 72'd8);
    check("t7_queue_empty", 72'(exp_q.size()), 72'd0);
    check("t7_sof_err", {71'd0, dut_if.SOF_ERR}, 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/median_window3x3.md
# median_window3x3

- Line-buffered 3x3 neighbourhood generator for the median filter: takes a raster pixel stream, one pixel per cycle, and presents all nine window pixels in parallel to the compare-exchange sorting network.
- Holds two full video lines, tracks row and column, and asserts a valid strobe only for windows that lie fully inside the frame.
- Sits directly upstream of the median sorter, which consumes WIN and OUT_VALID unchanged.

## Interface
- WIDTH, 8, bits per pixel
- LINE_LEN, 640, pixels per line; must be ≥ 3
- CLK  in  1  single clock; all state updates on its rising edge
- nRST  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  IN_PIX is accepted this cycle; no backpressure exists
- IN_SOF  in  1  start of frame; qualified by IN_VALID; marks pixel (0,0)
- IN_PIX  in  WIDTH  pixel value
- OUT_VALID  out  1  WIN holds a complete interior window
- WIN  out  9*WIDTH  window; tap k = 3*i + j at WIN[WIDTH*k +: WIDTH]
  - i = row: 0 top/oldest … 2 newest
  - j = column: 0 left … 2 right
  - k = 4 is the centre
- SOF_ERR  out  1  sticky frame-sync error (see Configuration)

## Operation
- Accepted pixel: a cycle with IN_VALID = 1.
  - Only accepted pixels advance state.
  - With IN_VALID = 0, nothing changes except OUT_VALID, which falls to 0.
- Position counters: col (0..LINE_LEN-1), row (saturating at 2).
  - IN_SOF on an accepted pixel: that pixel is (0,0); col and row restart from it.
  - Otherwise, col increments per accepted pixel.
  - At col = LINE_LEN-1, col wraps to 0 and row increments, saturating at 2.
- Line buffers LB1 and LB2, depth LINE_LEN, addressed by col.
  - Both are read before write at the same address.
  - Column vector = {LB2[col], LB1[col], IN_PIX}, i.e. rows r-2, r-1, r.
  - Update: LB2[col] ← old LB1[col]; LB1[col] ← IN_PIX.
  - RAM or register implementation is free, provided cycle behaviour matches this model.
- Window register: 3x3 shift register.
  - Each accepted pixel shifts the column vector in at j = 2; older columns move toward j = 0.
- Output: after an accepted pixel at (r,c) with r ≥ 2 and c ≥ 2:
  - OUT_VALID = 1 next cycle;
  - WIN holds rows r-2..r and columns c-2..c, centred on (r-1, c-1).
- Border windows (r < 2 or c < 2) are never flagged valid.
  - Stale taps from the previous line tail may appear in WIN; they are don't-care.
- Output count: (rows-2)*(LINE_LEN-2) OUT_VALID pulses per frame of `rows` lines.
- WIN holds its value when OUT_VALID = 0.

## Timing
- Latency: 1 cycle, accepted pixel → OUT_VALID/WIN.
- Sustained throughput: one window per cycle.
- Reset values:
  - OUT_VALID = 0, WIN = 0, SOF_ERR = 0, col = 0, row = 0.
  - Line buffer contents are not reset.
- Reset mid-frame:
  - Outputs clear immediately (asynchronous).
  - The first accepted pixel after release is treated as (0,0), whether or not IN_SOF is set.
- IN_SOF at col = 0 of a line is legal and restarts the row count.
- IN_SOF while the counters already point to (0,0) is a no-op.
- IN_SOF together with col wrap: IN_SOF wins.

## Configuration
- MEDIAN_WIN_SOF_CHECK_EN
  - Defined: SOF_ERR goes to 1 on the cycle after an accepted IN_SOF with col ≠ 0 (mid-line SOF).
    - It stays 1 until nRST.
    - Counters still restart as normal.
  - Undefined: SOF_ERR is tied to 0 and no check logic is built.
  - Window behaviour is identical in both builds.

## Test plan
Bench uses WIDTH = 8, LINE_LEN = 4, pixel value = 16*r + c.
1. Reset: hold nRST low → OUT_VALID = 0, WIN = 0, SOF_ERR = 0 with no clock edge required.
2. Continuous frame, SOF on (0,0), 5 rows.
   - First OUT_VALID one cycle after pixel 0x22, with WIN taps k0..k8 = 00,01,02,10,11,12,20,21,22.
   - Exactly 6 pulses; last window centre = 0x32.
3. Same frame with IN_VALID toggling every other cycle → identical window sequence.
   - OUT_VALID only on cycles following accepted pixels; never two valid cycles without an intervening accepted pixel.
4. IN_SOF asserted at pixel (2,1) → no OUT_VALID until new (2,2) is accepted.
   - SOF_ERR = 1 with MEDIAN_WIN_SOF_CHECK_EN defined, 0 without.
5. nRST pulsed low after pixel (3,2), with no IN_SOF afterwards.
   - OUT_VALID drops immediately.
   - The next accepted pixel is (0,0); the first new window follows the third accepted line's third pixel.
6. Back-to-back frames: second IN_SOF exactly at col = 0 after a full frame → SOF_ERR stays 0.
   - No OUT_VALID for the new frame's rows 0–1.
